// File: rtl/memctrl_host_if.sv
// Host-side sequencer for the MEMCTRL pin protocol: turns single-beat valid/ready requests
// into a SETUP phase followed by two CE pulses, returning read data on a one-cycle strobe.
module memctrl_host_if #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PH_CYC    = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WR,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_WDATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              BUSY,
    output logic              CE,
    output logic              CSB,
    output logic              WEB,
    output logic              OEB,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] IDATA,
    input  logic [DATA_W-1:0] ODATA
);

    localparam int unsigned MaxCyc = (SETUP_CYC > PH_CYC) ? SETUP_CYC : PH_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
    localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYC - 1);
    localparam logic [CntW-1:0] PhLd    = CntW'(PH_CYC - 1);

    typedef enum logic [2:0] {
        StIdle, StSetup, StCe1Hi, StCe1Lo, StCe2Hi, StCe2Lo
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              accept, capture;
    logic              ce_q, ce_d, csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
    logic              busy_q, busy_d, ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] idata_q, idata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        accept  = REQ_VALID && ready_q;
        if (state_q == StIdle) begin
            if (accept) begin
                state_d = StSetup;
                cnt_d   = SetupLd;
                wr_d    = REQ_WR;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = PhLd;
            unique case (state_q)
                StSetup: state_d = StCe1Hi;
                StCe1Hi: state_d = StCe1Lo;
                StCe1Lo: state_d = StCe2Hi;
                StCe2Hi: state_d = StCe2Lo;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are registered from the next state so pins change on the same edge as the FSM.
    always_comb begin
        ce_d        = state_d inside {StCe1Hi, StCe2Hi};
        csb_d       = !(state_d inside {StSetup, StCe1Hi});
        web_d       = !((state_d inside {StSetup, StCe1Hi}) && wr_d);
        oeb_d       = !((state_d inside {StSetup, StCe1Hi, StCe1Lo}) && !wr_d);
        busy_d      = state_d != StIdle;
        ready_d     = state_d == StIdle;
        addr_d      = accept ? REQ_ADDR : addr_q;
        idata_d     = (accept && REQ_WR) ? REQ_WDATA : idata_q;
        capture     = (state_q == StCe1Lo) && (state_d == StCe2Hi) && !wr_q;
        rsp_valid_d = capture;
        rsp_rdata_d = capture ? ODATA : rsp_rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            ce_q        <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            idata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            ce_q        <= ce_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            idata_q     <= idata_d;
        end
    end

    assign REQ_READY = ready_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign BUSY      = busy_q;
    assign CE        = ce_q;
    assign CSB       = csb_q;
    assign WEB       = web_q;
    assign OEB       = oeb_q;
    assign ADDR      = addr_q;
    assign IDATA     = idata_q;

endmodule

// File: tb/tb_memctrl_host_if.sv
// Bench for memctrl_host_if: a default-timing and a stretched-timing instance share one
// MEMCTRL memory model; pin traces are predicted from phase arithmetic per transaction.
module tb_memctrl_host_if;

    logic        clk, rst, sel;
    logic        req_valid, req_wr;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, odata;

    logic        a_ready, a_rsp, a_busy, a_ce, a_csb, a_web, a_oeb;
    logic [7:0]  a_rdata, a_idata;
    logic [15:0] a_addr;
    logic        b_ready, b_rsp, b_busy, b_ce, b_csb, b_web, b_oeb;
    logic [7:0]  b_rdata, b_idata;
    logic [15:0] b_addr;

    logic        m_ready, m_rsp, m_busy, m_ce, m_csb, m_web, m_oeb;
    logic [7:0]  m_rdata, m_idata;
    logic [15:0] m_addr;
    logic        a_valid, b_valid;

    int checks = 0;
    int errors = 0;

    bit   [7:0] mem     [65536];
    bit   [7:0] exp_mem [65536];
    logic [7:0] exp_idata [2];
    logic [7:0] exp_rdata [2];

    assign a_valid = req_valid & ~sel;
    assign b_valid = req_valid & sel;

    memctrl_host_if #(.ADDR_W(16), .DATA_W(8), .SETUP_CYC(1), .PH_CYC(1)) u_dut_a (
        .CLK(clk), .RST(rst), .REQ_VALID(a_valid), .REQ_READY(a_ready), .REQ_WR(req_wr),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .RSP_VALID(a_rsp), .RSP_RDATA(a_rdata),
        .BUSY(a_busy), .CE(a_ce), .CSB(a_csb), .WEB(a_web), .OEB(a_oeb), .ADDR(a_addr),
        .IDATA(a_idata), .ODATA(odata)
    );

    memctrl_host_if #(.ADDR_W(16), .DATA_W(8), .SETUP_CYC(2), .PH_CYC(3)) u_dut_b (
        .CLK(clk), .RST(rst), .REQ_VALID(b_valid), .REQ_READY(b_ready), .REQ_WR(req_wr),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .RSP_VALID(b_rsp), .RSP_RDATA(b_rdata),
        .BUSY(b_busy), .CE(b_ce), .CSB(b_csb), .WEB(b_web), .OEB(b_oeb), .ADDR(b_addr),
        .IDATA(b_idata), .ODATA(odata)
    );

    assign m_ready = sel ? b_ready : a_ready;
    assign m_rsp   = sel ? b_rsp   : a_rsp;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_ce    = sel ? b_ce    : a_ce;
    assign m_csb   = sel ? b_csb   : a_csb;
    assign m_web   = sel ? b_web   : a_web;
    assign m_oeb   = sel ? b_oeb   : a_oeb;
    assign m_rdata = sel ? b_rdata : a_rdata;
    assign m_idata = sel ? b_idata : a_idata;
    assign m_addr  = sel ? b_addr  : a_addr;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // MEMCTRL stand-in: stores on a selected write strobe, drives the addressed byte when OEB=0.
    always @(negedge clk) begin
        if (m_ce && !m_csb && !m_web) mem[m_addr] <= m_idata;
        odata <= !m_oeb ? mem[m_addr] : 8'h00;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected {CE,CSB,WEB,OEB,BUSY,READY,RSP_VALID} n edges after the accept edge.
    function automatic logic [6:0] ctrl_model(input int n, input int s, input int p,
                                              input bit wr);
        int  ph;
        logic ce, csb, web, oeb;
        ph  = (n < s) ? 1 : (n < s + p) ? 2 : (n < s + 2 * p) ? 3 :
              (n < s + 3 * p) ? 4 : (n < s + 4 * p) ? 5 : 0;
        ce  = (ph == 2) || (ph == 4);
        csb = !((ph == 1) || (ph == 2));
        web = !(((ph == 1) || (ph == 2)) && wr);
        oeb = !(((ph >= 1) && (ph <= 3)) && !wr);
        return {ce, csb, web, oeb, ph != 0, ph == 0, (n == s + 2 * p) && !wr};
    endfunction

    localparam logic [6:0] RstCtrl = 7'b0111000;

    // Call at a negedge; returns at the negedge after IDLE re-entry.
    task automatic do_txn(input bit wr, input logic [15:0] a, input logic [7:0] d);
        int s, p, w;
        logic [7:0] exp_rd;
        s = sel ? 2 : 1;
        p = sel ? 3 : 1;
        exp_rd = exp_mem[a];
        req_wr = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
        w = 0;
        while (!m_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!m_ready) begin
            chk("ready_timeout", 32'(m_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (wr) begin
            exp_mem[a] = d;
            exp_idata[sel] = d;
        end
        for (int n = 0; n <= s + 4 * p; n++) begin
            @(negedge clk);
            if (n == 0) req_valid = 1'b0;
            if (n == s + 2 * p && !wr) exp_rdata[sel] = exp_rd;
            chk("ctrl", 32'({m_ce, m_csb, m_web, m_oeb, m_busy, m_ready, m_rsp}),
                32'(ctrl_model(n, s, p, wr)));
            chk("addr", 32'(m_addr), 32'(a));
            chk("idata", 32'(m_idata), 32'(exp_idata[sel]));
            chk("rdata", 32'(m_rdata), 32'(exp_rdata[sel]));
        end
    endtask

    typedef struct {
        bit         wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    initial begin
        vec_t tbl [9];
        int i0, i1;
        tbl[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00};
        tbl[1] = '{1'b0, 16'h1234, 8'h00, 8'hA5};
        tbl[2] = '{1'b1, 16'h0001, 8'h11, 8'h00};
        tbl[3] = '{1'b0, 16'h0001, 8'h00, 8'h11};
        tbl[4] = '{1'b1, 16'hFFFF, 8'h5A, 8'h00};
        tbl[5] = '{1'b0, 16'hFFFF, 8'h00, 8'h5A};
        tbl[6] = '{1'b0, 16'h0002, 8'h00, 8'h00};
        tbl[7] = '{1'b1, 16'h0000, 8'hFF, 8'h00};
        tbl[8] = '{1'b0, 16'h0000, 8'h00, 8'hFF};
        exp_idata[0] = 8'h00; exp_idata[1] = 8'h00;
        exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;

        // Reset with a request pending: nothing may be accepted.
        sel = 1'b0; rst = 1'b1; req_valid = 1'b1;
        req_wr = 1'b1; req_addr = 16'h1234; req_wdata = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_ctrl_a", 32'({a_ce, a_csb, a_web, a_oeb, a_busy, a_ready, a_rsp}),
                32'(RstCtrl));
            chk("rst_ctrl_b", 32'({b_ce, b_csb, b_web, b_oeb, b_busy, b_ready, b_rsp}),
                32'(RstCtrl));
            chk("rst_addr", 32'(a_addr), 32'd0);
            chk("rst_data", 32'({a_idata, a_rdata}), 32'd0);
        end
        rst = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'({a_ready, a_busy, b_ready, b_busy}), 32'b1010);

        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            if (!tbl[i].wr) chk("tbl_rdata", 32'(m_rdata), 32'(tbl[i].exp_rdata));
        end

        // Back-to-back with REQ_VALID held high: write then read of the same address.
        req_wr = 1'b1; req_addr = 16'h0001; req_wdata = 8'h11; req_valid = 1'b1;
        i0 = -1; i1 = -1;
        for (int k = 0; k < 30 && i1 < 0; k++) begin
            if (m_ready) begin
                if (i0 < 0) i0 = k;
                else i1 = k;
            end
            @(negedge clk);
            if (i0 >= 0 && i1 < 0) req_wr = 1'b0;
        end
        req_valid = 1'b0;
        chk("b2b_spacing", 32'(i1 - i0), 32'd6);
        exp_mem[1] = 8'h11; exp_idata[0] = 8'h11;
        for (int k = 0; k < 20; k++) begin
            if (m_rsp) break;
            @(negedge clk);
        end
        chk("b2b_rsp_seen", 32'(m_rsp), 32'd1);
        chk("b2b_rdata", 32'(m_rdata), 32'h11);
        exp_rdata[0] = 8'h11;
        for (int k = 0; k < 20; k++) begin
            if (m_ready) break;
            @(negedge clk);
        end
        chk("b2b_idle", 32'(m_ready), 32'd1);

        // Stretched timing instance.
        sel = 1'b1;
        do_txn(1'b1, 16'h00AB, 8'h3C);
        do_txn(1'b0, 16'h00AB, 8'h00);
        chk("stretch_rdata", 32'(m_rdata), 32'h3C);
        do_txn(1'b0, 16'h1234, 8'h00);
        sel = 1'b0;

        // Reset while a read sits in CE1_LO.
        req_wr = 1'b0; req_addr = 16'h1234; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_ce1lo", 32'({m_ce, m_csb, m_oeb}), 32'b010);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ctrl", 32'({m_ce, m_csb, m_web, m_oeb, m_busy, m_ready, m_rsp}),
            32'(RstCtrl));
        chk("mid_rst_addr", 32'(m_addr), 32'd0);
        chk("mid_rst_rdata", 32'(m_rdata), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("mid_no_rsp", 32'({m_rsp, m_ce}), 32'd0);
        end
        exp_idata[0] = 8'h00; exp_idata[1] = 8'h00;
        exp_rdata[0] = 8'h00; exp_rdata[1] = 8'h00;
        do_txn(1'b0, 16'h1234, 8'h00);
        chk("after_rst_read", 32'(m_rdata), 32'hA5);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            sel = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 1) == 1) ? {12'h000, 4'($urandom)} : 16'($urandom);
            do_txn(1'($urandom_range(0, 1)), ra, 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/memctrl_host_if.md
Name: memctrl_host_if

Overview:
Bus-master sequencer that drives the MEMCTRL pin-level protocol (CSB/WEB/OEB/CE/ADDR/IDATA in, ODATA out) from a simple valid/ready request port. It turns single-beat read/write requests from an on-chip master (CPU wrapper, DMA, test controller) into the two-CE-pulse transaction MEMCTRL expects. It captures read data at the correct point and returns it on a one-cycle response strobe. It is the hardware counterpart of the host side of the MEMCTRL interface.

Parameters:
ADDR_W, 16, address width (matches MEMCTRL ADDR)
DATA_W, 8, data width (matches MEMCTRL IDATA/ODATA)
SETUP_CYC, 1, cycles CSB/WEB/ADDR/IDATA are driven before the first CE rise (>=1)
PH_CYC, 1, cycles per CE half-period, i.e. CE high time = CE low time (>=1)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
REQ_VALID  input  1  request present
REQ_READY  output  1  block can accept a request
REQ_WR  input  1  1 = write, 0 = read
REQ_ADDR  input  ADDR_W  request address
REQ_WDATA  input  DATA_W  write data
RSP_VALID  output  1  one-cycle strobe: read data valid
RSP_RDATA  output  DATA_W  captured read data
BUSY  output  1  transaction in progress (not IDLE)
CE  output  1  MEMCTRL chip enable strobe
CSB  output  1  MEMCTRL chip select, active-low
WEB  output  1  MEMCTRL write enable, active-low
OEB  output  1  MEMCTRL output enable, active-low
ADDR  output  ADDR_W  MEMCTRL address
IDATA  output  DATA_W  MEMCTRL write data
ODATA  input  DATA_W  MEMCTRL read data

Behaviour:
- Clocking/reset: single clock CLK; reset RST is synchronous, active-high. All outputs are registered.
- Reset values: REQ_READY=0 during reset, then 1 in IDLE. CE=0, CSB=1, WEB=1, OEB=1, ADDR=0, IDATA=0, RSP_VALID=0, RSP_RDATA=0, BUSY=0. FSM enters IDLE.
- Accept: a request is accepted on a rising edge with REQ_VALID & REQ_READY. REQ_WR/REQ_ADDR/REQ_WDATA are latched at that edge. REQ_READY=1 only in IDLE.
- FSM states: IDLE -> SETUP -> CE1_HI -> CE1_LO -> CE2_HI -> CE2_LO -> IDLE. A down-counter times each state: SETUP_CYC cycles for SETUP, PH_CYC cycles for each CE state.
- Output values per state:
  - IDLE: CE=0, CSB=1, WEB=1, OEB=1. ADDR/IDATA hold their last value.
  - SETUP: CSB=0, WEB=~wr, OEB=wr (OEB=0 for read, 1 for write), ADDR=addr, IDATA=wdata (write) or unchanged (read), CE=0.
  - CE1_HI: CE=1; CSB/WEB/OEB as in SETUP.
  - CE1_LO: CE=0, CSB=1, WEB=1; OEB unchanged.
  - CE2_HI: CE=1, OEB=1.
  - CE2_LO: CE=0.
- Read capture: on the edge leaving CE1_LO (entering CE2_HI), read requests do RSP_RDATA<=ODATA and RSP_VALID=1 for exactly one cycle. Writes never assert RSP_VALID; RSP_RDATA holds its value.
- Latency: accept edge T0; CE rises at T0+SETUP_CYC; RSP_VALID high in the cycle after edge T0+SETUP_CYC+2*PH_CYC; IDLE re-entered at edge T0+SETUP_CYC+4*PH_CYC.
- Back-to-back: the next accept is no earlier than one edge after IDLE re-entry, so the minimum request period is SETUP_CYC+4*PH_CYC+1 cycles (6 at defaults). REQ_VALID held high during a transaction is ignored until REQ_READY=1.
- No response backpressure: the consumer must take RSP_VALID when it occurs.
- Reset mid-transaction: the next edge with RST=1 forces all reset values immediately. Any pending RSP_VALID is dropped and no partial CE pulse is completed.
- CE is never high while in SETUP or IDLE. CSB never changes while CE=1.

Test Plan:
- Reset: RST=1 for 3 cycles with REQ_VALID=1 -> no accept, CE=0, CSB=WEB=OEB=1, ADDR=0, REQ_READY=0; after release REQ_READY=1 next cycle.
- Write, defaults: accept WR addr=16'h1234 data=8'hA5 at T0 -> T0+1 CE=1, CSB=0, WEB=0, OEB=1, ADDR=1234, IDATA=A5; T0+2 CE=0, CSB=1, WEB=1; T0+3 CE=1; T0+4 CE=0; T0+5 IDLE; RSP_VALID never asserted.
- Read with MEMCTRL model (write A5 to 1234 first): RD 16'h1234 -> OEB=0 from T0 to T0+3; RSP_VALID=1 for one cycle after edge T0+3 with RSP_RDATA=8'hA5.
- Stretched timing, SETUP_CYC=2, PH_CYC=3: each CE high/low lasts 3 cycles, first CE rise at T0+2, RSP_VALID after T0+8, IDLE at T0+14.
- Back-to-back: REQ_VALID held high with WR 0x0001/0x11 then RD 0x0001 -> accepts 6 cycles apart, read returns 8'h11.
- Reset in CE1_LO of a read -> next cycle all outputs at reset values, no RSP_VALID; a following read completes normally.
